// File: rtl/check_slider.sv
// ---------------------------------------------------------------------------
// check_slider
//   Sequential path checker for sliding pieces (bishop, rook, queen).
//   A request is accepted in IDLE, its geometry is judged in the same edge,
//   and the squares strictly between source and destination are then
//   inspected one per clock. The destination square itself is never read.
//
// Ports
//   clk          clock
//   reset_n      asynchronous reset, active-low
//   start        request strobe, sampled only while idle
//   mode         00 bishop, 01 rook, 10 queen, 11 illegal
//   old_x/old_y  source column/row
//   new_x/new_y  destination column/row
//   board_in     board contents, indexed board_in[y][x]
//   busy         high while a request is in progress
//   done         one-cycle pulse, result outputs valid
//   valid_move   geometry legal and path clear
//   blocked      geometry legal but an intermediate square is occupied
//   block_x/y    first occupied square on the path
// ---------------------------------------------------------------------------
module check_slider #(
  parameter int                 BOARD_N    = 8,
  parameter int                 COORD_W    = $clog2(BOARD_N),
  parameter int                 PIECE_W    = 4,
  parameter logic [PIECE_W-1:0] EMPTY_CODE = 4'd15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] old_x,
  input  logic [COORD_W-1:0] old_y,
  input  logic [COORD_W-1:0] new_x,
  input  logic [COORD_W-1:0] new_y,
  input  logic [PIECE_W-1:0] board_in [BOARD_N][BOARD_N],
  output logic               busy,
  output logic               done,
  output logic               valid_move,
  output logic               blocked,
  output logic [COORD_W-1:0] block_x,
  output logic [COORD_W-1:0] block_y
);

  // Deltas carry one extra bit so they can be treated as signed values.
  localparam int DW = COORD_W + 1;

  localparam logic [DW-1:0]      LIMIT_D = DW'(BOARD_N);
  localparam logic [DW-1:0]      ZERO_D  = {DW{1'b0}};
  localparam logic [DW-1:0]      ONE_D   = DW'(1'b1);
  localparam logic [COORD_W-1:0] ZERO_C  = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C   = COORD_W'(1'b1);
  localparam logic [COORD_W-1:0] NEG_C   = {COORD_W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_r;
  logic               busy_r;
  logic               done_r;
  logic               valid_r;
  logic               blocked_r;
  logic [COORD_W-1:0] block_x_r;
  logic [COORD_W-1:0] block_y_r;
  logic [COORD_W-1:0] ptr_x_r;
  logic [COORD_W-1:0] ptr_y_r;
  logic [COORD_W-1:0] step_x_r;
  logic [COORD_W-1:0] step_y_r;
  logic [COORD_W-1:0] dest_x_r;
  logic [COORD_W-1:0] dest_y_r;

  logic [DW-1:0]      dx_s;
  logic [DW-1:0]      dy_s;
  logic [DW-1:0]      adx_s;
  logic [DW-1:0]      ady_s;
  logic [DW-1:0]      span_s;
  logic               diag_s;
  logic               line_s;
  logic               range_bad_s;
  logic               shape_ok_s;
  logic               legal_s;
  logic               adjacent_s;
  logic [COORD_W-1:0] step_x_s;
  logic [COORD_W-1:0] step_y_s;
  logic [COORD_W-1:0] next_x_s;
  logic [COORD_W-1:0] next_y_s;
  logic [PIECE_W-1:0] square_s;
  logic               last_s;

  // Geometry of the request presented on the inputs (used only on an accepted start).
  always_comb begin
    dx_s   = {1'b0, new_x} - {1'b0, old_x};
    dy_s   = {1'b0, new_y} - {1'b0, old_y};
    adx_s  = dx_s[COORD_W] ? (ZERO_D - dx_s) : dx_s;
    ady_s  = dy_s[COORD_W] ? (ZERO_D - dy_s) : dy_s;
    span_s = (adx_s > ady_s) ? adx_s : ady_s;
    diag_s = (adx_s == ady_s);
    line_s = (dx_s == ZERO_D) || (dy_s == ZERO_D);
    range_bad_s = ({1'b0, old_x} >= LIMIT_D) || ({1'b0, old_y} >= LIMIT_D) ||
                  ({1'b0, new_x} >= LIMIT_D) || ({1'b0, new_y} >= LIMIT_D);
    case (mode)
      2'b00:   shape_ok_s = diag_s;
      2'b01:   shape_ok_s = line_s;
      2'b10:   shape_ok_s = diag_s || line_s;
      default: shape_ok_s = 1'b0;
    endcase
    // A zero span is the null move; diagonal and line tests both pass it, so exclude it here.
    legal_s    = shape_ok_s && !range_bad_s && (span_s != ZERO_D);
    adjacent_s = (span_s == ONE_D);
    // Unit steps live in COORD_W bits; adding all-ones wraps to a decrement.
    if (dx_s == ZERO_D) begin
      step_x_s = ZERO_C;
    end else begin
      step_x_s = dx_s[COORD_W] ? NEG_C : ONE_C;
    end
    if (dy_s == ZERO_D) begin
      step_y_s = ZERO_C;
    end else begin
      step_y_s = dy_s[COORD_W] ? NEG_C : ONE_C;
    end
  end

  // Square under the walk pointer and detection of the last intermediate square.
  always_comb begin
    next_x_s = ptr_x_r + step_x_r;
    next_y_s = ptr_y_r + step_y_r;
    square_s = board_in[ptr_y_r][ptr_x_r];
    last_s   = (next_x_s == dest_x_r) && (next_y_s == dest_y_r);
  end

  // Request FSM: accept, walk intermediates, pulse done, return to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
      blocked_r <= 1'b0;
      block_x_r <= ZERO_C;
      block_y_r <= ZERO_C;
      ptr_x_r   <= ZERO_C;
      ptr_y_r   <= ZERO_C;
      step_x_r  <= ZERO_C;
      step_y_r  <= ZERO_C;
      dest_x_r  <= ZERO_C;
      dest_y_r  <= ZERO_C;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            busy_r    <= 1'b1;
            valid_r   <= 1'b0;
            blocked_r <= 1'b0;
            block_x_r <= ZERO_C;
            block_y_r <= ZERO_C;
            dest_x_r  <= new_x;
            dest_y_r  <= new_y;
            step_x_r  <= step_x_s;
            step_y_r  <= step_y_s;
            ptr_x_r   <= old_x + step_x_s;
            ptr_y_r   <= old_y + step_y_s;
            if (!legal_s) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end else if (adjacent_s) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
              valid_r <= 1'b1;
            end else begin
              state_r <= S_WALK;
            end
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_WALK: begin
          if (square_s != EMPTY_CODE) begin
            blocked_r <= 1'b1;
            block_x_r <= ptr_x_r;
            block_y_r <= ptr_y_r;
            state_r   <= S_DONE;
            done_r    <= 1'b1;
          end else if (last_s) begin
            valid_r <= 1'b1;
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end else begin
            ptr_x_r <= next_x_s;
            ptr_y_r <= next_y_s;
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign valid_move = valid_r;
  assign blocked    = blocked_r;
  assign block_x    = block_x_r;
  assign block_y    = block_y_r;

endmodule

// File: tb/tb_check_slider.sv
// ---------------------------------------------------------------------------
// tb_check_slider
//   Bench for check_slider with an 8x8 and a 10x10 instance. A table of
//   hand-computed vectors covers the named scenarios, short sequences cover
//   start-while-busy and reset mid-walk, and random requests on random
//   boards are compared against a path-walking reference model.
// ---------------------------------------------------------------------------
module tb_check_slider;

  typedef struct {
    int s10, md, ox, oy, nx, ny, kind, px, py;
    int v, b, bx, by, lat;
  } vec_t;

  typedef struct {
    int v, b, bx, by, lat;
  } res_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_d;
  logic       sel10;
  logic [1:0] mode_d;
  logic [3:0] ox_d, oy_d, nx_d, ny_d;

  int         bm [16][16];
  logic [3:0] board8  [8][8];
  logic [3:0] board10 [10][10];

  logic       busy8, done8, valid8, blocked8;
  logic [2:0] bx8, by8;
  logic       busy10, done10, valid10, blocked10;
  logic [3:0] bx10, by10;
  logic       busy_m, done_m, valid_m, blocked_m;
  logic [3:0] bx_m, by_m;

  int tests = 0;
  int fails = 0;
  int lat, cap_v, cap_b, cap_bx, cap_by;

  always #5 clk = ~clk;

  always_comb begin
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        board8[y][x] = bm[y][x][3:0];
  end

  always_comb begin
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        board10[y][x] = bm[y][x][3:0];
  end

  check_slider #(.BOARD_N(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start_d & ~sel10), .mode(mode_d),
    .old_x(ox_d[2:0]), .old_y(oy_d[2:0]), .new_x(nx_d[2:0]), .new_y(ny_d[2:0]),
    .board_in(board8), .busy(busy8), .done(done8), .valid_move(valid8),
    .blocked(blocked8), .block_x(bx8), .block_y(by8)
  );

  check_slider #(.BOARD_N(10)) u_dut10 (
    .clk(clk), .reset_n(reset_n), .start(start_d & sel10), .mode(mode_d),
    .old_x(ox_d), .old_y(oy_d), .new_x(nx_d), .new_y(ny_d),
    .board_in(board10), .busy(busy10), .done(done10), .valid_move(valid10),
    .blocked(blocked10), .block_x(bx10), .block_y(by10)
  );

  assign busy_m    = sel10 ? busy10    : busy8;
  assign done_m    = sel10 ? done10    : done8;
  assign valid_m   = sel10 ? valid10   : valid8;
  assign blocked_m = sel10 ? blocked10 : blocked8;
  assign bx_m      = sel10 ? bx10      : {1'b0, bx8};
  assign by_m      = sel10 ? by10      : {1'b0, by8};

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_board(input int kind, input int px, input int py);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        bm[y][x] = (kind == 1) ? 2 : 15;
    if (kind == 2) bm[py][px] = 7;
  endtask

  // Reference: judge geometry by the rules, then walk the intermediate squares.
  function automatic res_t model(int n, int md, int ox, int oy, int nx, int ny);
    res_t r;
    int dx, dy, adx, ady, k, sx, sy;
    bit diag, line, shape;
    r = '{0, 0, 0, 0, 1};
    dx = nx - ox;
    dy = ny - oy;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    diag = (adx == ady);
    line = (dx == 0) || (dy == 0);
    case (md)
      0: shape = diag;
      1: shape = line;
      2: shape = diag || line;
      default: shape = 1'b0;
    endcase
    if (!shape || (dx == 0 && dy == 0) || ox >= n || oy >= n || nx >= n || ny >= n)
      return r;
    k  = ((adx > ady) ? adx : ady) - 1;
    sx = (dx > 0) ? 1 : ((dx < 0) ? -1 : 0);
    sy = (dy > 0) ? 1 : ((dy < 0) ? -1 : 0);
    for (int i = 1; i <= k; i++) begin
      if (bm[oy + i * sy][ox + i * sx] != 15) begin
        r.b = 1;
        r.bx = ox + i * sx;
        r.by = oy + i * sy;
        r.lat = i + 1;
        return r;
      end
    end
    r.v = 1;
    r.lat = k + 1;
    return r;
  endfunction

  // One request: drive at a falling edge, count cycles to done, capture results.
  task automatic do_req(input int s10, input int md, input int ox, input int oy,
                        input int nx, input int ny);
    @(negedge clk);
    sel10 = (s10 != 0);
    mode_d = md[1:0];
    ox_d = ox[3:0]; oy_d = oy[3:0]; nx_d = nx[3:0]; ny_d = ny[3:0];
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    lat = 0;
    chk("busy_after_start", busy_m, 1);
    for (int c = 1; c <= 30; c++) begin
      if (done_m) begin
        lat = c;
        cap_v = valid_m; cap_b = blocked_m; cap_bx = bx_m; cap_by = by_m;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("done_one_cycle", done_m, 0);
    chk("busy_released", busy_m, 0);
  endtask

  task automatic compare(input string tag, input res_t e);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_valid"}, cap_v, e.v);
    chk({tag, "_blocked"}, cap_b, e.b);
    chk({tag, "_block_x"}, cap_bx, e.bx);
    chk({tag, "_block_y"}, cap_by, e.by);
    chk({tag, "_valid_held"}, valid_m, e.v);
    chk({tag, "_blocked_held"}, blocked_m, e.b);
  endtask

  vec_t vecs [16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int ndone, first, n, s10, md, ox, oy, nx, ny, sx, sy, d;

    vecs = '{
      '{0, 0, 2, 0, 5, 3, 0, 0, 0,   1, 0, 0, 0, 3},
      '{0, 1, 0, 0, 0, 7, 2, 0, 4,   0, 1, 0, 4, 5},
      '{0, 0, 0, 0, 0, 3, 0, 0, 0,   0, 0, 0, 0, 1},
      '{0, 2, 1, 1, 3, 2, 0, 0, 0,   0, 0, 0, 0, 1},
      '{0, 2, 3, 3, 4, 4, 1, 0, 0,   1, 0, 0, 0, 1},
      '{0, 1, 7, 7, 0, 7, 2, 1, 7,   0, 1, 1, 7, 7},
      '{0, 2, 6, 1, 1, 6, 2, 4, 3,   0, 1, 4, 3, 3},
      '{0, 2, 3, 3, 3, 3, 0, 0, 0,   0, 0, 0, 0, 1},
      '{0, 3, 0, 0, 0, 5, 0, 0, 0,   0, 0, 0, 0, 1},
      '{0, 1, 0, 0, 0, 3, 2, 0, 3,   1, 0, 0, 0, 3},
      '{0, 2, 0, 0, 7, 7, 0, 0, 0,   1, 0, 0, 0, 7},
      '{1, 1, 0, 9, 9, 9, 0, 0, 0,   1, 0, 0, 0, 9},
      '{1, 3, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1},
      '{1, 1, 0, 0, 0, 12, 0, 0, 0,  0, 0, 0, 0, 1},
      '{1, 0, 9, 0, 0, 9, 2, 5, 4,   0, 1, 5, 4, 5},
      '{0, 1, 2, 5, 6, 5, 1, 0, 0,   0, 1, 3, 5, 2}
    };

    reset_n = 1'b0; start_d = 1'b0; sel10 = 1'b0; mode_d = 2'd0;
    ox_d = 4'd0; oy_d = 4'd0; nx_d = 4'd0; ny_d = 4'd0;
    set_board(0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_busy8", busy8, 0);
    chk("reset_done8", done8, 0);
    chk("reset_valid8", valid8, 0);
    chk("reset_blocked8", blocked8, 0);
    chk("reset_block_x8", bx8, 0);
    chk("reset_block_y8", by8, 0);
    chk("reset_busy10", busy10, 0);
    reset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      set_board(vecs[i].kind, vecs[i].px, vecs[i].py);
      do_req(vecs[i].s10, vecs[i].md, vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny);
      e = '{vecs[i].v, vecs[i].b, vecs[i].bx, vecs[i].by, vecs[i].lat};
      compare($sformatf("vec%0d", i), e);
    end

    // Start pulsed during a walk must be ignored and yield a single done.
    set_board(0, 0, 0);
    @(negedge clk);
    sel10 = 1'b0; mode_d = 2'd1;
    ox_d = 4'd0; oy_d = 4'd0; nx_d = 4'd0; ny_d = 4'd7;
    start_d = 1'b1;
    ndone = 0; first = 0; cap_v = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_d = (c == 2);
      if (c == 2) begin
        mode_d = 2'd2; ox_d = 4'd3; oy_d = 4'd3; nx_d = 4'd4; ny_d = 4'd4;
      end
      if (done_m) begin
        ndone++;
        if (first == 0) begin
          first = c;
          cap_v = valid_m;
        end
      end
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_latency", first, 7);
    chk("ignored_start_valid", cap_v, 1);

    // Reset mid-walk drops the request.
    @(negedge clk);
    sel10 = 1'b0; mode_d = 2'd2;
    ox_d = 4'd0; oy_d = 4'd0; nx_d = 4'd7; ny_d = 4'd7;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", busy8, 0);
    chk("midreset_done", done8, 0);
    chk("midreset_valid", valid8, 0);
    chk("midreset_blocked", blocked8, 0);
    chk("midreset_block_x", bx8, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("midreset_no_done", ndone, 0);

    // Random requests on random boards.
    for (int it = 0; it < 80; it++) begin
      s10 = int'($urandom_range(0, 1));
      n = (s10 != 0) ? 10 : 8;
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          bm[y][x] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : 15;
      md = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      ox = int'($urandom_range(0, n - 1));
      oy = int'($urandom_range(0, n - 1));
      nx = int'($urandom_range(0, n - 1));
      ny = int'($urandom_range(0, n - 1));
      if ($urandom_range(0, 3) != 0) begin
        sx = int'($urandom_range(0, 2)) - 1;
        sy = int'($urandom_range(0, 2)) - 1;
        d  = int'($urandom_range(1, n - 1));
        if ((sx != 0 || sy != 0) && ox + d * sx >= 0 && ox + d * sx < n &&
            oy + d * sy >= 0 && oy + d * sy < n) begin
          nx = ox + d * sx;
          ny = oy + d * sy;
        end
      end
      if (s10 != 0 && $urandom_range(0, 9) == 0) nx = int'($urandom_range(10, 15));
      e = model(n, md, ox, oy, nx, ny);
      do_req(s10, md, ox, oy, nx, ny);
      compare($sformatf("rand%0d_n%0d_m%0d_%0d_%0d_to_%0d_%0d", it, n, md, ox, oy, nx, ny), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
